// File: rtl/ysyx_23060187_exec_sequencer_if.sv
// ysyx_23060187_exec_sequencer_if: instruction/data memory handshake bundle of the exec sequencer
// Ports: imem_req_valid/imem_req_ready/imem_rsp_valid (fetch), dmem_req_valid/dmem_req_ready/
// dmem_we/dmem_rsp_valid (load/store). master = sequencer side, slave = memory side.
interface ysyx_23060187_exec_sequencer_if;
    logic imem_req_valid;
    logic imem_req_ready;
    logic imem_rsp_valid;
    logic dmem_req_valid;
    logic dmem_req_ready;
    logic dmem_we;
    logic dmem_rsp_valid;
    modport master (
        output imem_req_valid, dmem_req_valid, dmem_we,
        input  imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
    );
    modport slave (
        input  imem_req_valid, dmem_req_valid, dmem_we,
        output imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
    );
endinterface

// File: rtl/ysyx_23060187_exec_sequencer.sv
// ysyx_23060187_exec_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for the RV32 datapath
// Ports: clk, rst (sync, active high); bus (memory handshakes, master modport); inst (instruction
// register); alu_zero; controls ir_en, rf_wen, alu_ctrl, alu_b_sel, wb_sel, pc_wen, pc_sel;
// status halt, err, state_dbg. Optional macro YSYX_SEQ_PERF_CNT_EN adds cycle_cnt and instret_cnt.
module ysyx_23060187_exec_sequencer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    ysyx_23060187_exec_sequencer_if.master        bus,
    input  logic [31:0]                           inst,
    output logic                                  ir_en,
    input  logic                                  alu_zero,
    output logic                                  rf_wen,
    output logic [1:0]                            alu_ctrl,
    output logic                                  alu_b_sel,
    output logic [1:0]                            wb_sel,
    output logic                                  pc_wen,
    output logic [1:0]                            pc_sel,
    output logic                                  halt,
    output logic                                  err,
    output logic [3:0]                            state_dbg
`ifdef YSYX_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                      cycle_cnt,
    output logic [CNT_W-1:0]                      instret_cnt
`endif
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, FETCH_WAIT = 4'd2, DECODE = 4'd3, EXEC = 4'd4,
        MEM_REQ = 4'd5, MEM_WAIT = 4'd6, WB = 4'd7, HALT = 4'd8, ERR = 4'd9
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [31:0] EBREAK    = 32'h00100073;
    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    state_t         state, state_nx;
    logic [WCW-1:0] wait_cnt;
    logic           taken;
    logic [6:0]     opc;
    logic [2:0]     f3;
    logic           is_op, is_alu_op, waiting, timeout, in_flight, br_taken, bad_branch, legal, writes_rd;

    assign opc        = inst[6:0];
    assign f3         = inst[14:12];
    assign is_op      = opc == OPC_OP;
    assign is_alu_op  = is_op || opc == OPC_OPIMM;
    assign waiting    = state inside {FETCH, FETCH_WAIT, MEM_REQ, MEM_WAIT};
    // wait_cnt holds the cycles already spent here, so this is the WAIT_LIMIT-th cycle
    assign timeout    = wait_cnt == WCW'(WAIT_LIMIT - 1);
    assign in_flight  = state inside {EXEC, MEM_REQ, MEM_WAIT, WB};
    assign br_taken   = (f3 == 3'b000 && alu_zero) || (f3 == 3'b001 && !alu_zero);
    assign bad_branch = opc == OPC_BRANCH && f3[2:1] != 2'b00;
    assign legal      = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                    OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    assign writes_rd  = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
                                    OPC_OPIMM, OPC_OP};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            taken    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state_nx != state || !waiting) ? '0 : wait_cnt + WCW'(1);
            if (state == EXEC) taken <= br_taken;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = FETCH;
            FETCH:      state_nx = bus.imem_req_ready ? FETCH_WAIT : timeout ? ERR : FETCH;
            FETCH_WAIT: state_nx = bus.imem_rsp_valid ? DECODE : timeout ? ERR : FETCH_WAIT;
            DECODE:     state_nx = inst == EBREAK ? HALT : !legal ? ERR : EXEC;
            EXEC:       state_nx = bad_branch ? ERR : (opc == OPC_LOAD || opc == OPC_STORE) ? MEM_REQ : WB;
            MEM_REQ:    state_nx = bus.dmem_req_ready ? MEM_WAIT : timeout ? ERR : MEM_REQ;
            MEM_WAIT:   state_nx = bus.dmem_rsp_valid ? WB : timeout ? ERR : MEM_WAIT;
            WB:         state_nx = FETCH;
            HALT:       state_nx = HALT;
            default:    state_nx = ERR;
        endcase
    end

    // ALU controls stay valid from EXEC through WB so the address/result path is stable
    always_comb begin
        bus.imem_req_valid = state == FETCH;
        ir_en              = state == FETCH_WAIT && bus.imem_rsp_valid;
        bus.dmem_req_valid = state == MEM_REQ;
        bus.dmem_we        = state == MEM_REQ && opc == OPC_STORE;
        alu_ctrl           = !in_flight ? 2'b00
                           : (opc == OPC_BRANCH || (is_op && f3 == 3'b000 && inst[30])) ? 2'b01
                           : (is_alu_op && f3 == 3'b111) ? 2'b10
                           : (is_alu_op && f3 == 3'b110) ? 2'b11 : 2'b00;
        alu_b_sel          = in_flight && !(is_op || opc == OPC_BRANCH);
        pc_wen             = state == WB;
        pc_sel             = state != WB ? 2'b00
                           : (opc == OPC_JAL || (opc == OPC_BRANCH && taken)) ? 2'b01
                           : opc == OPC_JALR ? 2'b10 : 2'b00;
        rf_wen             = state == WB && writes_rd && inst[11:7] != 5'd0;
        wb_sel             = state != WB ? 2'b00
                           : opc == OPC_LUI ? 2'b11
                           : opc == OPC_LOAD ? 2'b01
                           : (opc == OPC_JAL || opc == OPC_JALR) ? 2'b10 : 2'b00;
        halt               = state == HALT;
        err                = state == ERR;
        state_dbg          = state;
    end

`ifdef YSYX_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (!(state inside {IDLE, HALT, ERR})) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state == WB || (state == DECODE && state_nx == HALT)) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif
endmodule
